// File: rtl/dac_wave_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dac_wave_sched
//  Purpose  : Periodic waveform sample scheduler for an I2C DAC write
//             controller. Produces constant / sawtooth / triangle / square
//             samples and issues one write per update tick through the
//             wr_req / wr_data / ready handshake. Overruns and stalled
//             transfers are reported on sticky flags.
//  Revision : 1.0 - initial release
// ============================================================================
module dac_wave_sched #(
    parameter logic [6:0]  DEV_ID  = 7'h48,
    parameter int unsigned DEF_DIV = 50000,
    parameter int unsigned TO_CYC  = 16
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [7:0]  step,
    input  logic [7:0]  level,
    input  logic [15:0] div,
    input  logic        clr_flags,
    input  logic        dac_ready,
    output logic        dac_wr_req,
    output logic [6:0]  dac_device_id,
    output logic [7:0]  dac_wr_data,
    output logic [7:0]  cur_sample,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [15:0] DEF_P = 16'(DEF_DIV);
    localparam int          TW    = $clog2(TO_CYC) + 1;
    // WAIT_BUSY lasts TO_CYC-1 cycles so that the flag becomes visible
    // exactly TO_CYC cycles after the request cycle.
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 2);

    localparam logic [1:0] M_CONST = 2'd0;
    localparam logic [1:0] M_SAW   = 2'd1;
    localparam logic [1:0] M_TRI   = 2'd2;
    localparam logic [1:0] M_SQR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------
    // Tick counter
    // ------------------------------------------------------------------
    logic [15:0] cnt;
    logic [15:0] per_q;
    logic [15:0] div_eff;
    logic [15:0] period_cur;
    logic        tick;

    // The period is captured whenever the counter sits at 0, so a new div
    // only applies from the next period onwards.
    assign div_eff    = (div == 16'd0) ? DEF_P : div;
    assign period_cur = (cnt == 16'd0) ? div_eff : per_q;
    assign tick       = en && (cnt == (period_cur - 16'd1));

    // Free-running period counter, held at zero while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 16'd0;
            per_q <= 16'd0;
        end else if (!en) begin
            cnt   <= 16'd0;
        end else begin
            if (cnt == 16'd0) begin
                per_q <= div_eff;
            end
            cnt <= tick ? 16'd0 : (cnt + 16'd1);
        end
    end

    // ------------------------------------------------------------------
    // Waveform generator state
    // ------------------------------------------------------------------
    logic [1:0] mode_q;
    logic [7:0] s_q;      // working sample
    logic [7:0] p_q;      // square-wave phase accumulator
    logic       d_q;      // triangle direction, 0 = up
    logic [7:0] sample_q; // last issued sample
    logic [7:0] s_nxt;
    logic [7:0] p_nxt;
    logic       d_nxt;
    logic [8:0] sum9;
    logic       issue;

    assign sum9 = {1'b0, s_q} + {1'b0, step};

    // Next sample for the currently registered mode.
    always_comb begin
        s_nxt = s_q;
        p_nxt = p_q;
        d_nxt = d_q;
        case (mode_q)
            M_CONST: begin
                s_nxt = level;
            end
            M_SAW: begin
                s_nxt = sum9[7:0];
            end
            M_TRI: begin
                if (!d_q) begin
                    if (sum9 >= 9'd255) begin
                        s_nxt = 8'd255;
                        d_nxt = 1'b1;
                    end else begin
                        s_nxt = sum9[7:0];
                    end
                end else begin
                    if ({1'b0, s_q} <= {1'b0, step}) begin
                        s_nxt = 8'd0;
                        d_nxt = 1'b0;
                    end else begin
                        s_nxt = s_q - step;
                    end
                end
            end
            M_SQR: begin
                p_nxt = p_q + step;
                s_nxt = p_nxt[7] ? 8'd0 : level;
            end
            default: begin
                s_nxt = s_q;
            end
        endcase
    end

    // Sample registers; a mode change restarts the waveform and overrides
    // any same-cycle update of the working state (issued data is kept).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= 2'd0;
            s_q      <= 8'd0;
            p_q      <= 8'd0;
            d_q      <= 1'b0;
            sample_q <= 8'd0;
        end else begin
            if (issue) begin
                s_q      <= s_nxt;
                p_q      <= p_nxt;
                d_q      <= d_nxt;
                sample_q <= s_nxt;
            end
            if (mode != mode_q) begin
                mode_q <= mode;
                s_q    <= 8'd0;
                p_q    <= 8'd0;
                d_q    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    logic [TW-1:0] to_cnt;
    logic          set_ovr;
    logic          set_to;
    logic          to_clr;
    logic          to_inc;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        set_ovr   = 1'b0;
        set_to    = 1'b0;
        to_clr    = 1'b0;
        to_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    if (dac_ready) begin
                        issue     = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        set_ovr   = 1'b1;
                    end
                end
            end
            REQ: begin
                set_ovr   = tick;
                to_clr    = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                set_ovr = tick;
                if (!dac_ready) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    set_to    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    to_inc    = 1'b1;
                end
            end
            WAIT_DONE: begin
                set_ovr = tick;
                if (dac_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Timeout counter for the wait-for-busy phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (to_clr) begin
            to_cnt <= '0;
        end else if (to_inc) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Sticky status flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
            if (set_to) begin
                timeout <= 1'b1;
            end else if (clr_flags) begin
                timeout <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dac_wr_req    = (state == REQ);
    assign dac_device_id = DEV_ID;
    assign dac_wr_data   = sample_q;
    assign cur_sample    = sample_q;
    assign busy          = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dac_wave_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_wave_sched
//  Purpose  : Directed self-checking bench for dac_wave_sched with a simple
//             cycle-level DAC controller model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dac_wave_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  step;
    logic [7:0]  level;
    logic [15:0] div;
    logic        clr_flags;
    logic        dac_ready;
    logic        dac_wr_req;
    logic [6:0]  dac_device_id;
    logic [7:0]  dac_wr_data;
    logic [7:0]  cur_sample;
    logic        busy;
    logic        overrun;
    logic        timeout;

    dac_wave_sched #(
        .DEV_ID  (7'h48),
        .DEF_DIV (50000),
        .TO_CYC  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mode          (mode),
        .step          (step),
        .level         (level),
        .div           (div),
        .clr_flags     (clr_flags),
        .dac_ready     (dac_ready),
        .dac_wr_req    (dac_wr_req),
        .dac_device_id (dac_device_id),
        .dac_wr_data   (dac_wr_data),
        .cur_sample    (cur_sample),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    // DAC controller model: ready stays high for 3 cycles after a request,
    // then drops for blen cycles. With noresp set, requests are ignored.
    int pre;
    int lo;
    int blen;
    bit noresp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= 0;
            lo  <= 0;
        end else if (dac_wr_req && !noresp) begin
            pre <= 3;
        end else if (pre > 0) begin
            pre <= pre - 1;
            if (pre == 1) lo <= blen;
        end else if (lo > 0) begin
            lo <= lo - 1;
        end
    end

    assign dac_ready = (lo == 0);

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
        cyc++;
    endtask

    // Advance until dac_wr_req is seen on a falling edge; returns its cycle.
    task automatic wait_req(input int limit, output int at);
        bit found;
        found = 0;
        for (int i = 0; i < limit; i++) begin
            nclk();
            if (dac_wr_req) begin
                found = 1;
                break;
            end
        end
        if (!found) check("req_wait_expired", 0, 1);
        at = cyc;
    endtask

    int tri_exp [7] = '{100, 200, 255, 155, 55, 0, 100};
    int sqr_exp [4] = '{'hA5, 'h00, 'h00, 'hA5};
    int r;
    int prev;

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        mode      = 2'd1;
        step      = 8'h10;
        level     = 8'h00;
        div       = 16'd100;
        clr_flags = 1'b0;
        blen      = 20;
        noresp    = 1'b0;

        // Reset state
        nclk();
        nclk();
        check("rst_wr_req",  dac_wr_req,    0);
        check("rst_data",    dac_wr_data,   0);
        check("rst_cur",     cur_sample,    0);
        check("rst_busy",    busy,          0);
        check("rst_overrun", overrun,       0);
        check("rst_timeout", timeout,       0);
        check("rst_dev_id",  dac_device_id, 'h48);

        // Sawtooth 0x10 step, period 100, wraps to 0x00 on the 16th update
        rst  = 1'b1;
        prev = cyc;
        for (int k = 1; k <= 16; k++) begin
            wait_req(250, r);
            check(k == 1 ? "saw_first_lat" : "saw_period", r - prev, 100);
            check("saw_data", dac_wr_data, (k * 16) % 256);
            check("saw_cur",  cur_sample,  (k * 16) % 256);
            prev = r;
        end
        check("saw_overrun", overrun, 0);

        // Triangle, step 100
        mode = 2'd2;
        step = 8'd100;
        for (int k = 0; k < 7; k++) begin
            wait_req(250, r);
            check("tri_period", r - prev, 100);
            check("tri_data", dac_wr_data, tri_exp[k]);
            prev = r;
        end

        // Square, level A5, phase step 64
        mode  = 2'd3;
        level = 8'hA5;
        step  = 8'd64;
        for (int k = 0; k < 4; k++) begin
            wait_req(250, r);
            check("sqr_data", dac_wr_data, sqr_exp[k]);
            prev = r;
        end

        // Constant 3C
        mode  = 2'd0;
        level = 8'h3C;
        wait_req(250, r);
        check("const_data", dac_wr_data, 'h3C);
        check("const_period", r - prev, 100);

        // Overrun: period 10, DAC busy 30 cycles per write
        div  = 16'd10;
        blen = 30;
        mode = 2'd1;
        step = 8'd1;
        wait_req(250, r);
        check("ovr_first_data", dac_wr_data, 1);
        clr_flags = 1'b1;
        nclk();
        clr_flags = 1'b0;
        check("ovr_cleared", overrun, 0);
        repeat (9) nclk();
        check("ovr_set", overrun, 1);
        prev = r;
        wait_req(100, r);
        check("ovr_interval", r - prev, 40);
        check("ovr_data", dac_wr_data, 2);

        // Timeout: DAC ignores this request, ready stays high
        noresp = 1'b1;
        repeat (15) nclk();
        check("to_before", timeout, 0);
        nclk();
        check("to_set", timeout, 1);
        check("to_idle", busy, 0);
        noresp = 1'b0;
        prev = r;
        wait_req(100, r);
        check("to_next_req", r - prev, 20);
        check("to_next_data", dac_wr_data, 3);

        // Reset in WAIT_DONE, then sawtooth restarts from step
        div  = 16'd100;
        step = 8'h10;
        repeat (6) nclk();
        check("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_req",     dac_wr_req,    0);
        check("mid_rst_data",    dac_wr_data,   0);
        check("mid_rst_cur",     cur_sample,    0);
        check("mid_rst_busy",    busy,          0);
        check("mid_rst_overrun", overrun,       0);
        check("mid_rst_timeout", timeout,       0);
        check("mid_rst_dev_id",  dac_device_id, 'h48);
        nclk();
        nclk();
        rst  = 1'b1;
        prev = cyc;
        // First request lands in the (P+1)th cycle counting the release cycle.
        wait_req(250, r);
        check("restart_lat",  r - prev, 100);
        check("restart_data", dac_wr_data, 'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
